// File: rtl/trigger_block_requester_pkg.sv
// Shared types and helpers for the trigger block requester.
package trigger_block_requester_pkg;

    // T1_offset keeps its fixed width regardless of the block address width
    localparam int T1_OFFSET_BITS = 9;
    localparam int DROP_BITS      = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE
    } state_t;

    // Increment that sticks at all-ones
    function automatic logic [DROP_BITS-1:0] sat_inc(input logic [DROP_BITS-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/trig_job_fifo.sv
// Synchronous show-ahead FIFO holding queued readout jobs.
// A push while full is still accepted when a pop happens in the same cycle.
module trig_job_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem[rd_ptr[AW-1:0]];

    // Storage array; no reset needed, validity is tracked by the pointers
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din_i;
    end

    // Pointer update; extra MSB distinguishes full from empty
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/trigger_block_requester.sv
// Turns each T1 rising edge into a readout job (start block, length, L4 flags),
// queues jobs and issues them one block at a time over a valid/ready interface.
module trigger_block_requester
    import trigger_block_requester_pkg::*;
#(
    parameter int NUM_L4     = 4,
    parameter int BLOCK_BITS = 9,
    parameter int LEN_BITS   = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      T1_i,
    input  logic [T1_OFFSET_BITS-1:0] T1_offset_i,
    input  logic [NUM_L4-1:0]         l4_new_i,
    input  logic [BLOCK_BITS-1:0]     wr_block_i,
    input  logic [LEN_BITS-1:0]       readout_len_i,
    output logic                      req_valid_o,
    output logic [BLOCK_BITS-1:0]     req_block_o,
    output logic                      req_first_o,
    output logic                      req_last_o,
    output logic [NUM_L4-1:0]         req_l4new_o,
    input  logic                      req_ready_i,
    output logic                      busy_o,
    output logic                      overflow_o,
    output logic [DROP_BITS-1:0]      dropped_o
);

    localparam int JW = BLOCK_BITS + LEN_BITS + NUM_L4;

    logic                  t1_q;
    logic                  cap_vld;
    logic [JW-1:0]         cap_job;
    logic [BLOCK_BITS-1:0] start_w;
    logic [LEN_BITS-1:0]   len_w;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [JW-1:0]         fifo_dout;
    logic                  pop;

    state_t                state;
    logic [BLOCK_BITS-1:0] job_blk;
    logic [LEN_BITS-1:0]   job_len;
    logic [NUM_L4-1:0]     job_l4;
    logic [LEN_BITS-1:0]   cnt;

    // Start block wraps naturally in the block address space
    assign start_w = wr_block_i - BLOCK_BITS'(T1_offset_i);
    assign len_w   = (readout_len_i == '0) ? LEN_BITS'(1) : readout_len_i;

    // Edge detect and job capture; the job is pushed on the following clock
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            t1_q    <= 1'b0;
            cap_vld <= 1'b0;
            cap_job <= '0;
        end else begin
            t1_q    <= T1_i;
            cap_vld <= T1_i && !t1_q;
            if (T1_i && !t1_q) cap_job <= {start_w, len_w, l4_new_i};
        end
    end

    trig_job_fifo #(
        .WIDTH (JW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (cap_vld),
        .din_i   (cap_job),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Pop when idle, or when the last block of the current job is accepted
    always_comb begin
        pop = 1'b0;
        case (state)
            ST_IDLE:  pop = !fifo_empty;
            ST_ISSUE: pop = req_ready_i && (cnt == '0) && !fifo_empty;
            default:  pop = 1'b0;
        endcase
    end

    // Sticky overflow flag and saturating drop counter
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            overflow_o <= 1'b0;
            dropped_o  <= '0;
        end else if (cap_vld && fifo_full && !pop) begin
            overflow_o <= 1'b1;
            dropped_o  <= sat_inc(dropped_o);
        end
    end

    // Issue FSM: outputs are registered and only move on an accepted beat
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= ST_IDLE;
            job_blk     <= '0;
            job_len     <= '0;
            job_l4      <= '0;
            cnt         <= '0;
            req_valid_o <= 1'b0;
            req_block_o <= '0;
            req_first_o <= 1'b0;
            req_last_o  <= 1'b0;
            req_l4new_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        {job_blk, job_len, job_l4} <= fifo_dout;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    req_valid_o <= 1'b1;
                    req_block_o <= job_blk;
                    req_first_o <= 1'b1;
                    req_last_o  <= (job_len == LEN_BITS'(1));
                    req_l4new_o <= job_l4;
                    cnt         <= job_len - 1'b1;
                    state       <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (req_ready_i) begin
                        req_first_o <= 1'b0;
                        req_l4new_o <= '0;
                        if (cnt == '0) begin
                            req_valid_o <= 1'b0;
                            req_last_o  <= 1'b0;
                            if (pop) begin
                                {job_blk, job_len, job_l4} <= fifo_dout;
                                state <= ST_LOAD;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            req_block_o <= req_block_o + 1'b1;
                            cnt         <= cnt - 1'b1;
                            req_last_o  <= (cnt == LEN_BITS'(1));
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_trigger_block_requester.sv
// Bench for trigger_block_requester: table vectors, corner sequences and a
// randomized phase, all checked against a job-queue reference model.
module tb_trigger_block_requester;

    localparam int NUM_L4 = 4;
    localparam int BB     = 9;
    localparam int LB     = 4;
    localparam int DEPTH  = 16;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          T1_i = 1'b0;
    logic [8:0]    T1_offset_i = '0;
    logic [NUM_L4-1:0] l4_new_i = '0;
    logic [BB-1:0] wr_block_i = '0;
    logic [LB-1:0] readout_len_i = '0;
    logic          req_ready_i = 1'b0;
    logic          req_valid_o;
    logic [BB-1:0] req_block_o;
    logic          req_first_o;
    logic          req_last_o;
    logic [NUM_L4-1:0] req_l4new_o;
    logic          busy_o;
    logic          overflow_o;
    logic [7:0]    dropped_o;

    trigger_block_requester #(
        .NUM_L4(NUM_L4), .BLOCK_BITS(BB), .LEN_BITS(LB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .T1_i(T1_i), .T1_offset_i(T1_offset_i),
        .l4_new_i(l4_new_i), .wr_block_i(wr_block_i), .readout_len_i(readout_len_i),
        .req_valid_o(req_valid_o), .req_block_o(req_block_o), .req_first_o(req_first_o),
        .req_last_o(req_last_o), .req_l4new_o(req_l4new_o), .req_ready_i(req_ready_i),
        .busy_o(busy_o), .overflow_o(overflow_o), .dropped_o(dropped_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [8:0] start;
        int         len;
        logic [3:0] l4;
    } job_t;

    typedef struct {
        logic [8:0] wr;
        logic [8:0] off;
        logic [3:0] len;
        logic [3:0] l4;
        int         exp_first;
        int         exp_n;
        int         exp_last;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;

    // reference model state
    job_t exp_q[$];
    int   model_drops = 0;
    bit   t1_prev = 0;

    // drive-side knobs
    logic [8:0] cur_wr = '0, cur_off = '0;
    logic [3:0] cur_len = '0, cur_l4 = '0;
    bit   rdy = 0, rdy_rand = 0;

    // monitor state
    int   beat = 0;
    int   ev_done = 0;
    int   rec_first = 0, rec_last = 0, rec_n = 0;
    bit   pv_stall = 0;
    logic [14:0] prev_act = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // One clock: drive inputs just after the edge and update the model on T1 rising edges
    task automatic cyc(input bit t1);
        job_t j;
        @(posedge clk_i);
        #1;
        T1_i = t1;
        wr_block_i = cur_wr;
        T1_offset_i = cur_off;
        readout_len_i = cur_len;
        l4_new_i = cur_l4;
        req_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : rdy;
        if (t1 && !t1_prev) begin
            j.start = 9'(cur_wr - cur_off);
            j.len   = (cur_len == 0) ? 1 : int'(cur_len);
            j.l4    = cur_l4;
            // stalled downstream holds one job in flight plus a full queue
            if (exp_q.size() >= DEPTH + 1) begin
                if (model_drops < 255) model_drops++;
            end else exp_q.push_back(j);
        end
        t1_prev = t1;
    endtask

    task automatic wait_drain(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (exp_q.size() == 0 && !busy_o) return;
            cyc(0);
        end
        chk("drain_timeout", 32'(exp_q.size()), 0);
    endtask

    // Output monitor: each valid cycle must match the head job's next block
    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            pv_stall = 0;
        end else if (req_valid_o) begin
            logic [14:0] act, exp;
            job_t j;
            act = {req_block_o, req_first_o, req_last_o, req_l4new_o};
            if (pv_stall) chk("stall_stable", 32'(act), 32'(prev_act));
            if (exp_q.size() == 0) begin
                chk("unexpected_req", 32'(act), 0);
            end else begin
                j = exp_q[0];
                exp = {9'(j.start + 9'(beat)), beat == 0, beat == j.len - 1,
                       (beat == 0) ? j.l4 : 4'h0};
                chk("beat", 32'(act), 32'(exp));
                if (req_ready_i) begin
                    if (beat == 0) rec_first = int'(req_block_o);
                    beat++;
                    if (beat == j.len) begin
                        rec_last = int'(req_block_o);
                        rec_n = beat;
                        void'(exp_q.pop_front());
                        beat = 0;
                        ev_done++;
                    end
                end
            end
            pv_stall = !req_ready_i;
            prev_act = act;
        end else begin
            pv_stall = 0;
        end
    end

    vec_t vecs[5];

    initial begin
        int ev0, k;
        vecs[0] = '{wr: 9'd100, off: 9'd10,  len: 4'd4,  l4: 4'hA, exp_first: 90,  exp_n: 4,  exp_last: 93};
        vecs[1] = '{wr: 9'd3,   off: 9'd6,   len: 4'd3,  l4: 4'h5, exp_first: 509, exp_n: 3,  exp_last: 511};
        vecs[2] = '{wr: 9'd510, off: 9'd0,   len: 4'd4,  l4: 4'h1, exp_first: 510, exp_n: 4,  exp_last: 1};
        vecs[3] = '{wr: 9'd0,   off: 9'd0,   len: 4'd0,  l4: 4'hF, exp_first: 0,   exp_n: 1,  exp_last: 0};
        vecs[4] = '{wr: 9'd5,   off: 9'd511, len: 4'd15, l4: 4'h3, exp_first: 6,   exp_n: 15, exp_last: 20};

        // reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_outputs", {req_valid_o, req_block_o, req_first_o, req_last_o, req_l4new_o,
                              busy_o, overflow_o, dropped_o}, 0);
        @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        rdy = 1;

        // table vectors: start/length/wrap plus 3-clock latency from idle
        foreach (vecs[i]) begin
            cur_wr = vecs[i].wr; cur_off = vecs[i].off;
            cur_len = vecs[i].len; cur_l4 = vecs[i].l4;
            cyc(1);
            k = 0;
            for (int c = 1; c <= 8 && k == 0; c++) begin
                cyc(0);
                @(negedge clk_i);
                if (req_valid_o) k = c;
            end
            chk("latency", 32'(k - 1), 3);
            wait_drain(60);
            chk("tbl_first", 32'(rec_first), 32'(vecs[i].exp_first));
            chk("tbl_nblocks", 32'(rec_n), 32'(vecs[i].exp_n));
            chk("tbl_last", 32'(rec_last), 32'(vecs[i].exp_last));
        end

        // long T1 is one job; a one-cycle gap makes a second one
        ev0 = ev_done;
        cur_wr = 9'd20; cur_off = 9'd5; cur_len = 4'd2; cur_l4 = 4'h6;
        repeat (5) cyc(1);
        cyc(0);
        cyc(1);
        cyc(0);
        wait_drain(60);
        chk("multi_cycle_t1_events", 32'(ev_done - ev0), 2);

        // stalled downstream: fill the queue past capacity, then release in order
        ev0 = ev_done;
        rdy = 0;
        cur_len = 4'd1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            cur_wr = 9'(i * 7); cur_off = 9'd0; cur_l4 = 4'(i);
            cyc(1);
            cyc(0);
        end
        repeat (3) cyc(0);
        @(negedge clk_i);
        chk("overflow_set", 32'(overflow_o), 1);
        chk("dropped_cnt", 32'(dropped_o), 32'(model_drops));
        rdy = 1;
        wait_drain(400);
        chk("overflow_events", 32'(ev_done - ev0), DEPTH + 1);

        // random ready with single-block events
        ev0 = ev_done;
        rdy_rand = 1;
        cur_len = 4'd0;
        for (int i = 0; i < 20; i++) begin
            cur_wr = 9'($urandom); cur_off = 9'($urandom);
            cur_l4 = 4'($urandom);
            cyc(1);
            repeat (9) cyc(0);
        end
        rdy_rand = 0;
        rdy = 1;
        wait_drain(400);
        chk("random_events", 32'(ev_done - ev0), 20);

        // reset while issuing
        rdy = 0;
        cur_wr = 9'd50; cur_off = 9'd0; cur_len = 4'd8; cur_l4 = 4'h9;
        cyc(1);
        repeat (5) cyc(0);
        @(negedge clk_i);
        chk("valid_before_reset", 32'(req_valid_o), 1);
        #2 rst_n_i = 1'b0;
        #1;
        chk("rst_valid", 32'(req_valid_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_dropped", {31'd0, overflow_o} + 32'(dropped_o), 0);
        exp_q.delete();
        beat = 0;
        t1_prev = 0;
        model_drops = 0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        rdy = 1;
        ev0 = ev_done;
        cur_wr = 9'd200; cur_off = 9'd1; cur_len = 4'd3; cur_l4 = 4'h2;
        cyc(1);
        cyc(0);
        wait_drain(60);
        chk("post_reset_events", 32'(ev_done - ev0), 1);
        chk("post_reset_first", 32'(rec_first), 199);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
